// File: rtl/dkong_sound_cmd_if_if.sv
// dkong_sound_cmd_if_if: CPU-side write bus and status readback of the sound command port.
interface dkong_sound_cmd_if_if;
    logic       we;
    logic [1:0] sel;
    logic [2:0] ab;
    logic [7:0] db;
    logic       stat_clr;
    logic [7:0] status;
    modport master (output we, sel, ab, db, stat_clr, input status);
    modport slave (input we, sel, ab, db, stat_clr, output status);
endinterface

// File: rtl/dkong_sound_cmd_if.sv
// dkong_sound_cmd_if: main-CPU sound command latches (6H/5H/4H/3D), SACK sync and request timeout.
// DKONG_SNDCMD_STRETCH_EN enables the per-bit minimum-low stretch on the 6H triggers.
module dkong_sound_cmd_if #(
    parameter int         TIMEOUT_CYC = 24576,
    parameter logic [6:0] RST_6H      = 7'h7F,
    parameter int         STRETCH_CYC = 1024
) (
    input  logic                 W_CLK_24576M,
    input  logic                 W_RESETn,
    dkong_sound_cmd_if_if.slave  bus,
    input  logic                 I_SACK,
    output logic [6:0]           O_6H_Q,
    output logic                 O_5H_Q0,
    output logic [1:0]           O_4H_Q,
    output logic [4:0]           O_3D_Q
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [2:0]    sync;
    logic          pend;
    logic          tmo;
    logic [TW-1:0] cnt;
    logic          wr6;
    logic          wr5;
    logic          wr4;
    logic          wr3;
    logic          req_set;
    logic          sack_edge;
    logic          hit;
    logic          unused;

    assign wr6       = bus.we && bus.sel == 2'd0;
    assign wr5       = bus.we && bus.sel == 2'd1 && bus.ab == 3'd0;
    assign wr4       = bus.we && bus.sel == 2'd2 && bus.ab[2:1] == 2'd0;
    assign wr3       = bus.we && bus.sel == 2'd3;
    assign req_set   = wr5 && bus.db[0] && !O_5H_Q0;
    assign sack_edge = sync[1] ^ sync[2];
    assign hit       = pend && cnt == TW'(TIMEOUT_CYC - 1);
    assign bus.status = {5'b0, tmo, pend, sync[1]};
    assign unused    = ^bus.db[7:5] ^ (STRETCH_CYC == 0);

    always_ff @(posedge W_CLK_24576M or negedge W_RESETn)
        if (!W_RESETn) begin
            O_5H_Q0 <= 1'b0;
            O_4H_Q  <= '0;
            O_3D_Q  <= '0;
            sync    <= '0;
            pend    <= 1'b0;
            tmo     <= 1'b0;
            cnt     <= '0;
        end else begin
            sync <= {sync[1:0], I_SACK};
            if (wr5) O_5H_Q0 <= bus.db[0];
            if (wr4) O_4H_Q[bus.ab[0]] <= bus.db[0];
            if (wr3) O_3D_Q <= bus.db[4:0];
            // a fresh request outranks both the timeout and a coincident acknowledge
            if (req_set) begin
                pend <= 1'b1;
                cnt  <= '0;
            end else if (hit)
                pend <= 1'b0;
            else if (pend && sack_edge)
                pend <= 1'b0;
            else if (pend)
                cnt <= cnt + 1'b1;
            tmo <= (hit && !req_set) ? 1'b1 : bus.stat_clr ? 1'b0 : tmo;
        end

`ifdef DKONG_SNDCMD_STRETCH_EN
    localparam int SW = $clog2(STRETCH_CYC + 1);
    for (genvar i = 0; i < 7; i++) begin : g_6h
        logic          q;
        logic          want;
        logic          wr;
        logic [SW-1:0] left;
        assign wr        = wr6 && bus.ab == 3'(i);
        assign O_6H_Q[i] = q;
        // a rise requested while the low window is still open is parked in want
        always_ff @(posedge W_CLK_24576M or negedge W_RESETn)
            if (!W_RESETn) begin
                q    <= RST_6H[i];
                want <= 1'b0;
                left <= '0;
            end else if (wr && !bus.db[0]) begin
                q    <= 1'b0;
                want <= 1'b0;
                left <= SW'(STRETCH_CYC);
            end else begin
                if (left != '0) left <= left - 1'b1;
                if ((wr || want) && left <= SW'(1)) begin
                    q    <= 1'b1;
                    want <= 1'b0;
                end else if (wr)
                    want <= 1'b1;
            end
    end
`else
    for (genvar i = 0; i < 7; i++) begin : g_6h
        logic q;
        assign O_6H_Q[i] = q;
        always_ff @(posedge W_CLK_24576M or negedge W_RESETn)
            if (!W_RESETn)
                q <= RST_6H[i];
            else if (wr6 && bus.ab == 3'(i))
                q <= bus.db[0];
    end
`endif
endmodule

// File: tb/tb_dkong_sound_cmd_if.sv
// tb_dkong_sound_cmd_if: vector table, directed handshake/timeout sequences and a random run
// against a cycle-stamped behavioural model of the sound command port.
module tb_dkong_sound_cmd_if;
    localparam int     T   = 16;
    localparam int     S   = 8;
    localparam longint INF = 64'd1 << 40;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sack  = 1'b0;
    logic [6:0] q6;
    logic       q5;
    logic [1:0] q4;
    logic [4:0] q3;

    dkong_sound_cmd_if_if bus();

    dkong_sound_cmd_if #(.TIMEOUT_CYC(T), .STRETCH_CYC(S)) dut (
        .W_CLK_24576M(clk),
        .W_RESETn    (rst_n),
        .bus         (bus),
        .I_SACK      (sack),
        .O_6H_Q      (q6),
        .O_5H_Q0     (q5),
        .O_4H_Q      (q4),
        .O_3D_Q      (q3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [1:0] sel;
        logic [2:0] ab;
        logic [7:0] db;
        logic [6:0] e6;
        logic       e5;
        logic [1:0] e4;
        logic [4:0] e3;
    } vec_t;

    vec_t tbl [12];

    int         total = 0;
    int         bad   = 0;
    longint     cyc   = 0;
    logic [6:0] m6;
    logic       m5;
    logic [1:0] m4;
    logic [4:0] m3;
    logic       pend;
    logic       tmo;
    longint     req_at;
    longint     zero_at [7];
    longint     rise_at [7];
    logic [2:0] h;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m6 = 7'h7F; m5 = 1'b0; m4 = '0; m3 = '0;
        pend = 1'b0; tmo = 1'b0; req_at = 0; h = '0;
        for (int i = 0; i < 7; i++) begin
            zero_at[i] = -INF;
            rise_at[i] = INF;
        end
    endtask

    // one clock edge of the reference: latches, 1 ms-style request timer, two-stage SACK delay
    task automatic model_step();
        logic   seen;
        logic   rs;
        logic   fired;
        int     a;
        cyc++;
        seen  = h[1] != h[2];
        h     = {h[1:0], sack};
        rs    = bus.we && bus.sel == 2'd1 && bus.ab == 3'd0 && bus.db[0] && !m5;
        fired = 1'b0;
        a     = int'(bus.ab);
        if (bus.we && bus.sel == 2'd0 && a < 7) begin
            if (!bus.db[0]) begin
                m6[a] = 1'b0;
                zero_at[a] = cyc;
                rise_at[a] = INF;
            end else begin
`ifdef DKONG_SNDCMD_STRETCH_EN
                if (!m6[a]) rise_at[a] = (zero_at[a] + S > cyc) ? zero_at[a] + S : cyc;
`else
                m6[a] = 1'b1;
`endif
            end
        end
        for (int i = 0; i < 7; i++)
            if (!m6[i] && rise_at[i] <= cyc) begin
                m6[i] = 1'b1;
                rise_at[i] = INF;
            end
        if (bus.we && bus.sel == 2'd1 && a == 0) m5 = bus.db[0];
        if (bus.we && bus.sel == 2'd2 && a < 2) m4[a] = bus.db[0];
        if (bus.we && bus.sel == 2'd3) m3 = bus.db[4:0];
        if (rs) begin
            pend = 1'b1;
            req_at = cyc;
        end else if (pend && cyc == req_at + T) begin
            pend = 1'b0;
            fired = 1'b1;
        end else if (pend && seen)
            pend = 1'b0;
        if (fired) tmo = 1'b1;
        else if (bus.stat_clr) tmo = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [2:0] ab, input logic [7:0] db);
        bus.we = 1'b1; bus.sel = sel; bus.ab = ab; bus.db = db;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_model();
        chk("rnd_6h", q6, m6);
        chk("rnd_5h", q5, m5);
        chk("rnd_4h", q4, m4);
        chk("rnd_3d", q3, m3);
        chk("rnd_status", bus.status, {5'b0, tmo, pend, h[1]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 3'd0, 8'h00, 7'h7E, 1'b0, 2'd0, 5'h00};
        tbl[1]  = '{1'b1, 2'd0, 3'd7, 8'h00, 7'h7E, 1'b0, 2'd0, 5'h00};
        tbl[2]  = '{1'b1, 2'd3, 3'd5, 8'hF5, 7'h7E, 1'b0, 2'd0, 5'h15};
        tbl[3]  = '{1'b1, 2'd2, 3'd1, 8'h01, 7'h7E, 1'b0, 2'd2, 5'h15};
        tbl[4]  = '{1'b1, 2'd2, 3'd5, 8'h01, 7'h7E, 1'b0, 2'd2, 5'h15};
        tbl[5]  = '{1'b1, 2'd1, 3'd3, 8'h01, 7'h7E, 1'b0, 2'd2, 5'h15};
        tbl[6]  = '{1'b1, 2'd0, 3'd6, 8'hFE, 7'h3E, 1'b0, 2'd2, 5'h15};
        tbl[7]  = '{1'b1, 2'd3, 3'd0, 8'h0A, 7'h3E, 1'b0, 2'd2, 5'h0A};
        tbl[8]  = '{1'b0, 2'd3, 3'd0, 8'h1F, 7'h3E, 1'b0, 2'd2, 5'h0A};
        tbl[9]  = '{1'b1, 2'd2, 3'd0, 8'h01, 7'h3E, 1'b0, 2'd3, 5'h0A};
        tbl[10] = '{1'b1, 2'd2, 3'd1, 8'h00, 7'h3E, 1'b0, 2'd1, 5'h0A};
        tbl[11] = '{1'b1, 2'd1, 3'd0, 8'h00, 7'h3E, 1'b0, 2'd1, 5'h0A};
        bus.we = 1'b0; bus.sel = '0; bus.ab = '0; bus.db = '0; bus.stat_clr = 1'b0;
        do_reset();
        tick();
        chk("rst_6h", q6, 7'h7F);
        chk("rst_5h", q5, 1'b0);
        chk("rst_4h", q4, 2'd0);
        chk("rst_3d", q3, 5'd0);
        chk("rst_status", bus.status, 8'h00);

        foreach (tbl[i]) begin
            bus.we = tbl[i].we; bus.sel = tbl[i].sel; bus.ab = tbl[i].ab; bus.db = tbl[i].db;
            tick();
            chk($sformatf("vec%0d_6h", i), q6, tbl[i].e6);
            chk($sformatf("vec%0d_5h", i), q5, tbl[i].e5);
            chk($sformatf("vec%0d_4h", i), q4, tbl[i].e4);
            chk($sformatf("vec%0d_3d", i), q3, tbl[i].e3);
            chk($sformatf("vec%0d_status", i), bus.status, 8'h00);
        end
        bus.we = 1'b0;

        wr(2'd1, 3'd0, 8'h01); tick(); bus.we = 1'b0;
        chk("req_5h", q5, 1'b1);
        chk("req_status", bus.status, 8'h02);
        repeat (5) tick();
        sack = 1'b1;
        for (int k = 0; k < 4 && bus.status[1]; k++) tick();
        chk("ack_pend", bus.status[1], 1'b0);
        chk("ack_tmo", bus.status[2], 1'b0);

        wr(2'd1, 3'd0, 8'h00); tick();
        wr(2'd1, 3'd0, 8'h01); tick(); bus.we = 1'b0;
        repeat (T - 1) tick();
        chk("tmo_early", bus.status[2:1], 2'b01);
        bus.stat_clr = 1'b1; tick(); bus.stat_clr = 1'b0;
        chk("tmo_set_wins", bus.status[2:1], 2'b10);
        tick();
        chk("tmo_sticky", bus.status[2], 1'b1);
        bus.stat_clr = 1'b1; tick(); bus.stat_clr = 1'b0;
        chk("tmo_clr", bus.status[2], 1'b0);

        wr(2'd1, 3'd0, 8'h00); tick();
        wr(2'd1, 3'd0, 8'h01); tick(); bus.we = 1'b0;
        repeat (5) tick();
        chk("mid_pend", bus.status[1], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_status", bus.status, 8'h00);
        chk("async_6h", q6, 7'h7F);
        chk("async_5h", q5, 1'b0);
        chk("async_4h", q4, 2'd0);
        chk("async_3d", q3, 5'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_status", bus.status, 8'h00);

        sack = 1'b0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bus.we       = ($urandom_range(2) == 0);
            bus.sel      = 2'($urandom_range(3));
            bus.ab       = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom_range(7));
            bus.db       = 8'($urandom);
            bus.stat_clr = ($urandom_range(29) == 0);
            if ($urandom_range(24) == 0) sack = ~sack;
            tick();
            chk_model();
        end
        bus.we = 1'b0; bus.stat_clr = 1'b0;

`ifdef DKONG_SNDCMD_STRETCH_EN
        wr(2'd0, 3'd0, 8'h00); tick(); bus.we = 1'b0;
        chk("str_low0", q6[0], 1'b0);
        tick();
        chk("str_low1", q6[0], 1'b0);
        wr(2'd0, 3'd0, 8'h01); tick(); bus.we = 1'b0;
        chk("str_low2", q6[0], 1'b0);
        for (int k = 3; k < S; k++) begin
            tick();
            chk($sformatf("str_low%0d", k), q6[0], 1'b0);
        end
        tick();
        chk("str_rise", q6[0], 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
